// File: rtl/hysteresis_threshold.sv
// Canny hysteresis stage: classifies NMS strips into a 3x3 class window and emits one edge decision per shift.
// Optional edge counter is built only when HYST_EDGE_COUNT_EN is defined; otherwise edge_count is tied to 0.
module hysteresis_threshold #(
    parameter int PIX_W = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               frame_start,
    input  logic [1:0]         shift_dir,
    input  logic [PIX_W-1:0]   non_max [0:2],
    input  logic [PIX_W-1:0]   hi_thresh,
    input  logic [PIX_W-1:0]   lo_thresh,
    output logic               out_valid,
    output logic               edge_out,
    output logic [CNT_W-1:0]   edge_count
);

    localparam logic [1:0] CLS_NONE   = 2'b00;
    localparam logic [1:0] CLS_WEAK   = 2'b01;
    localparam logic [1:0] CLS_STRONG = 2'b10;

    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    logic [1:0] cls_q [0:2][0:2];
    logic [1:0] cls_d [0:2][0:2];
    logic [1:0] strip_cls [0:2];
    logic [1:0] fill_q, fill_d;
    logic       out_valid_q, out_valid_d;
    logic       edge_out_q, edge_out_d;
    logic       shift_en;
    logic       nbr_strong;

    // Thresholds are applied at shift time only; stored classes are never revisited.
    for (genvar gi = 0; gi < 3; gi++) begin : g_classify
        assign strip_cls[gi] = (non_max[gi] >= hi_thresh) ? CLS_STRONG :
                               (non_max[gi] >= lo_thresh) ? CLS_WEAK   : CLS_NONE;
    end

    assign shift_en = (shift_dir != 2'b00) && !frame_start;

    always_comb begin
        cls_d = cls_q;
        if (frame_start) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    cls_d[r][c] = CLS_NONE;
                end
            end
        end else begin
            case (shift_dir)
                DIR_RIGHT: begin
                    for (int r = 0; r < 3; r++) begin
                        cls_d[r][0] = cls_q[r][1];
                        cls_d[r][1] = cls_q[r][2];
                        cls_d[r][2] = strip_cls[r];
                    end
                end
                DIR_LEFT: begin
                    for (int r = 0; r < 3; r++) begin
                        cls_d[r][2] = cls_q[r][1];
                        cls_d[r][1] = cls_q[r][0];
                        cls_d[r][0] = strip_cls[r];
                    end
                end
                DIR_DOWN: begin
                    for (int c = 0; c < 3; c++) begin
                        cls_d[0][c] = cls_q[1][c];
                        cls_d[1][c] = cls_q[2][c];
                        cls_d[2][c] = strip_cls[c];
                    end
                end
                default: ;
            endcase
        end
    end

    // Decision looks at the post-shift window so the result lands with the shift.
    always_comb begin
        nbr_strong = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!(r == 1 && c == 1) && cls_d[r][c] == CLS_STRONG) begin
                    nbr_strong = 1'b1;
                end
            end
        end
    end

    always_comb begin
        fill_d      = fill_q;
        out_valid_d = 1'b0;
        edge_out_d  = edge_out_q;
        if (frame_start) begin
            fill_d     = 2'd0;
            edge_out_d = 1'b0;
        end else if (shift_en) begin
            if (fill_q != 2'd3) begin
                fill_d = fill_q + 2'd1;
            end
            out_valid_d = (fill_d == 2'd3);
            edge_out_d  = (cls_d[1][1] == CLS_STRONG) ||
                          ((cls_d[1][1] == CLS_WEAK) && nbr_strong);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    cls_q[r][c] <= CLS_NONE;
                end
            end
            fill_q      <= 2'd0;
            out_valid_q <= 1'b0;
            edge_out_q  <= 1'b0;
        end else begin
            cls_q       <= cls_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            edge_out_q  <= edge_out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign edge_out  = edge_out_q;

`ifdef HYST_EDGE_COUNT_EN
    logic [CNT_W-1:0] edge_count_q, edge_count_d;

    // Counts alongside the output it reports, so edge_count already includes the visible edge.
    always_comb begin
        edge_count_d = edge_count_q;
        if (frame_start) begin
            edge_count_d = '0;
        end else if (out_valid_d && edge_out_d && (edge_count_q != {CNT_W{1'b1}})) begin
            edge_count_d = edge_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            edge_count_q <= '0;
        end else begin
            edge_count_q <= edge_count_d;
        end
    end

    assign edge_count = edge_count_q;
`else
    assign edge_count = '0;
`endif

endmodule
